// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical tags with group allocation,
// multi-port release and a single head checkpoint for branch recovery.
module phys_reg_free_list #(
    parameter int CELLS           = 128,
    parameter int ARCH_REGS       = 32,
    parameter int ALLOC_PORTS     = 4,
    parameter int FREE_PORTS      = 4,
    parameter int PHYS_ADDR_WIDTH = $clog2(CELLS),
    parameter int CNT_WIDTH       = $clog2(CELLS) + 1
) (
    input  logic                                   clk,
    input  logic                                   async_rst_n,
    input  logic                                   clk_en,
    input  logic                                   alloc_valid,
    input  logic [ALLOC_PORTS-1:0]                 alloc_req,
    output logic                                   alloc_ready,
    output logic [ALLOC_PORTS*PHYS_ADDR_WIDTH-1:0] alloc_addr,
    input  logic [FREE_PORTS-1:0]                  free_en,
    input  logic [FREE_PORTS*PHYS_ADDR_WIDTH-1:0]  free_addr,
    input  logic                                   chkpt_save,
    input  logic                                   chkpt_restore,
    output logic [CNT_WIDTH-1:0]                   free_count,
    output logic                                   overflow_err
);
    localparam int PW = PHYS_ADDR_WIDTH;
    localparam int CW = CNT_WIDTH;

    logic [PW-1:0] fifo_q [CELLS];
    logic [CW-1:0] head_q, tail_q, chk_q, head_d, tail_d, chk_d;
    logic [CW-1:0] count, n_req, n_fire, m_free, space, rank;
    logic [PW-1:0] k;
    logic [PW-1:0] wr_idx [FREE_PORTS];
    logic [FREE_PORTS-1:0] wr_en;
    logic overflow_q, fire;

    assign count        = tail_q - head_q;
    assign free_count   = count;
    assign overflow_err = overflow_q;
    assign n_req        = CW'($countones(alloc_req));
    assign m_free       = CW'($countones(free_en));
    assign alloc_ready  = clk_en && !chkpt_restore && count >= n_req;
    assign fire         = alloc_valid && alloc_ready;
    assign n_fire       = fire ? n_req : '0;
    // Room left for pushes once this cycle's grant has been taken out.
    assign space        = CW'(CELLS) - (count - n_fire);
    assign head_d       = chkpt_restore ? chk_q : head_q + n_fire;
    assign chk_d        = (chkpt_save && !chkpt_restore) ? head_q + n_fire : chk_q;
    assign tail_d       = tail_q + rank;

    always_comb begin
        alloc_addr = '0;
        k = '0;
        for (int j = 0; j < ALLOC_PORTS; j++) begin
            if (alloc_req[j]) begin
                alloc_addr[j*PW +: PW] = fifo_q[head_q[PW-1:0] + k];
                k = k + PW'(1);
            end
        end
    end

    // Compact released tags in port order; once capacity runs out the rest drop.
    always_comb begin
        rank = '0;
        wr_en = '0;
        for (int j = 0; j < FREE_PORTS; j++) begin
            wr_idx[j] = tail_q[PW-1:0] + rank[PW-1:0];
            wr_en[j] = free_en[j] && rank < space;
            rank = rank + CW'(wr_en[j]);
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            head_q     <= '0;
            tail_q     <= CW'(CELLS - ARCH_REGS);
            chk_q      <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < CELLS; i++)
                fifo_q[i] <= (i < CELLS - ARCH_REGS) ? PW'(ARCH_REGS + i) : '0;
        end else if (clk_en) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            chk_q      <= chk_d;
            overflow_q <= overflow_q || m_free > space;
            for (int j = 0; j < FREE_PORTS; j++)
                if (wr_en[j]) fifo_q[wr_idx[j]] <= free_addr[j*PW +: PW];
        end
    end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: directed scenarios for the physical register free list.
module tb_phys_reg_free_list;
    localparam int W = 7;

    logic         clk = 1'b0;
    logic         async_rst_n = 1'b0;
    logic         clk_en, alloc_valid, alloc_ready, chkpt_save, chkpt_restore, overflow_err;
    logic [3:0]   alloc_req, free_en;
    logic [4*W-1:0] alloc_addr, free_addr;
    logic [7:0]   free_count;
    int checks = 0;
    int failures = 0;

    phys_reg_free_list dut (
        .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
        .alloc_valid(alloc_valid), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
        .alloc_addr(alloc_addr), .free_en(free_en), .free_addr(free_addr),
        .chkpt_save(chkpt_save), .chkpt_restore(chkpt_restore),
        .free_count(free_count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        clk_en = 1'b1; alloc_valid = 1'b0; alloc_req = '0; free_en = '0; free_addr = '0;
        chkpt_save = 1'b0; chkpt_restore = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        async_rst_n = 1'b0;
        #2;
        async_rst_n = 1'b1;
        #1;
    endtask

    task automatic fire4(input int times);
        for (int i = 0; i < times; i++) begin
            alloc_valid = 1'b1; alloc_req = 4'b1111;
            cyc();
        end
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        alloc_req = 4'b0001;
        #1;
        checks++; if (free_count !== 8'd96) begin failures++; $display("FAIL reset_count got=%0d exp=96", free_count); end
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow_err); end
        checks++; if (alloc_addr[0 +: W] !== 7'd32) begin failures++; $display("FAIL reset_addr0 got=%0d exp=32", alloc_addr[0 +: W]); end
        clk_en = 1'b0; alloc_valid = 1'b1; free_en = 4'b0001;
        #1;
        checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL clken_ready got=%0b exp=0", alloc_ready); end
        cyc();
        checks++; if (free_count !== 8'd96) begin failures++; $display("FAIL clken_hold got=%0d exp=96", free_count); end
        idle();
    endtask

    task automatic test_group_alloc();
        do_reset();
        alloc_valid = 1'b1; alloc_req = 4'b1111;
        #1;
        checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL g4_ready got=%0b exp=1", alloc_ready); end
        checks++; if (alloc_addr !== {7'd35, 7'd34, 7'd33, 7'd32}) begin failures++; $display("FAIL g4_addr got=%h exp=%h", alloc_addr, {7'd35, 7'd34, 7'd33, 7'd32}); end
        cyc();
        checks++; if (free_count !== 8'd92) begin failures++; $display("FAIL g4_count got=%0d exp=92", free_count); end
        idle();
    endtask

    task automatic test_sparse_req();
        do_reset();
        alloc_valid = 1'b1; alloc_req = 4'b1010;
        #1;
        checks++; if (alloc_addr !== {7'd33, 7'd0, 7'd32, 7'd0}) begin failures++; $display("FAIL sparse_addr got=%h exp=%h", alloc_addr, {7'd33, 7'd0, 7'd32, 7'd0}); end
        cyc();
        idle();
        alloc_req = 4'b0001;
        #1;
        checks++; if (free_count !== 8'd94) begin failures++; $display("FAIL sparse_count got=%0d exp=94", free_count); end
        checks++; if (alloc_addr[0 +: W] !== 7'd34) begin failures++; $display("FAIL sparse_next got=%0d exp=34", alloc_addr[0 +: W]); end
        idle();
    endtask

    task automatic test_drain();
        do_reset();
        fire4(23);
        alloc_valid = 1'b1; alloc_req = 4'b0011;
        cyc();
        checks++; if (free_count !== 8'd2) begin failures++; $display("FAIL drain_count got=%0d exp=2", free_count); end
        alloc_req = 4'b0111;
        #1;
        checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL short_ready got=%0b exp=0", alloc_ready); end
        cyc();
        checks++; if (free_count !== 8'd2) begin failures++; $display("FAIL short_hold got=%0d exp=2", free_count); end
        alloc_req = 4'b0011;
        #1;
        checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL exact_ready got=%0b exp=1", alloc_ready); end
        checks++; if (alloc_addr[0 +: 2*W] !== {7'd127, 7'd126}) begin failures++; $display("FAIL exact_addr got=%h exp=%h", alloc_addr[0 +: 2*W], {7'd127, 7'd126}); end
        cyc();
        alloc_req = 4'b0001;
        #1;
        checks++; if (alloc_ready !== 1'b0 || free_count !== 8'd0) begin failures++; $display("FAIL empty got=ready%0b/count%0d exp=ready0/count0", alloc_ready, free_count); end
        alloc_req = 4'b0000;
        #1;
        checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL zero_req_ready got=%0b exp=1", alloc_ready); end
        cyc();
        checks++; if (free_count !== 8'd0) begin failures++; $display("FAIL zero_req_count got=%0d exp=0", free_count); end
        idle();
    endtask

    task automatic test_free_order();
        do_reset();
        alloc_valid = 1'b1; alloc_req = 4'b0011;
        free_en = 4'b0101; free_addr = {7'd0, 7'd9, 7'd5, 7'd7};
        cyc();
        idle();
        checks++; if (free_count !== 8'd96) begin failures++; $display("FAIL free_bal_count got=%0d exp=96", free_count); end
        fire4(23);
        alloc_valid = 1'b1; alloc_req = 4'b0011;
        cyc();
        #1;
        checks++; if (alloc_addr[0 +: 2*W] !== {7'd9, 7'd7}) begin failures++; $display("FAIL free_order got=%h exp=%h", alloc_addr[0 +: 2*W], {7'd9, 7'd7}); end
        idle();
    endtask

    task automatic test_checkpoint();
        do_reset();
        alloc_valid = 1'b1; alloc_req = 4'b1111; chkpt_save = 1'b1;
        cyc();
        idle();
        fire4(2);
        checks++; if (free_count !== 8'd84) begin failures++; $display("FAIL ckpt_pre got=%0d exp=84", free_count); end
        alloc_valid = 1'b1; alloc_req = 4'b1111; chkpt_restore = 1'b1; chkpt_save = 1'b1;
        #1;
        checks++; if (alloc_ready !== 1'b0) begin failures++; $display("FAIL restore_ready got=%0b exp=0", alloc_ready); end
        cyc();
        checks++; if (free_count !== 8'd92) begin failures++; $display("FAIL restore_count got=%0d exp=92", free_count); end
        idle();
        fire4(1);
        chkpt_restore = 1'b1;
        cyc();
        idle();
        alloc_req = 4'b0001;
        #1;
        checks++; if (free_count !== 8'd92) begin failures++; $display("FAIL restore2_count got=%0d exp=92", free_count); end
        checks++; if (alloc_addr[0 +: W] !== 7'd36) begin failures++; $display("FAIL restore_addr got=%0d exp=36", alloc_addr[0 +: W]); end
        idle();
    endtask

    task automatic test_overflow_and_reset();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            free_en = 4'b1111; free_addr = {7'(4*c+3), 7'(4*c+2), 7'(4*c+1), 7'(4*c)};
            cyc();
        end
        idle();
        checks++; if (free_count !== 8'd128 || overflow_err !== 1'b0) begin failures++; $display("FAIL full got=count%0d/ovf%0b exp=count128/ovf0", free_count, overflow_err); end
        free_en = 4'b0001; free_addr = {21'd0, 7'd100};
        cyc();
        idle();
        checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow_err); end
        checks++; if (free_count !== 8'd128) begin failures++; $display("FAIL ovf_count got=%0d exp=128", free_count); end
        alloc_req = 4'b1111;
        #1;
        checks++; if (alloc_addr !== {7'd35, 7'd34, 7'd33, 7'd32}) begin failures++; $display("FAIL full_addr got=%h exp=%h", alloc_addr, {7'd35, 7'd34, 7'd33, 7'd32}); end
        alloc_valid = 1'b1; alloc_req = 4'b0001; free_en = 4'b1111;
        async_rst_n = 1'b0;
        #1;
        checks++; if (free_count !== 8'd96 || overflow_err !== 1'b0) begin failures++; $display("FAIL midrst got=count%0d/ovf%0b exp=count96/ovf0", free_count, overflow_err); end
        checks++; if (alloc_addr[0 +: W] !== 7'd32) begin failures++; $display("FAIL midrst_addr got=%0d exp=32", alloc_addr[0 +: W]); end
        #1;
        async_rst_n = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        #12;
        async_rst_n = 1'b1;
        cyc();
        test_reset();
        test_group_alloc();
        test_sparse_req();
        test_drain();
        test_free_order();
        test_checkpoint();
        test_overflow_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
